axi_mem_slave: RTL and testbench

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

---
 rtl/axi_mem_slave.sv | 240 ++++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_slave.sv
// AXI4 memory target: MEM_WORDS x 32-bit storage behind independent
// single-outstanding write and read state machines. Bursts are INCR or FIXED;
// reserved burst types and out-of-range start addresses complete with SLVERR.
module axi_mem_slave #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axi_awid,
    input  logic [31:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [1:0]  s_axi_awburst,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [7:0]  s_axi_bid,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [7:0]  s_axi_arid,
    input  logic [31:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [1:0]  s_axi_arburst,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [7:0]  s_axi_rid,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [31:0] mem [MEM_WORDS];

    w_state_t    w_state_q, w_state_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [7:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [1:0]  wburst_q, wburst_d;
    logic        werr_q, werr_d;
    logic [7:0]  bid_q, bid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        mem_we;
    logic        rdy_q, rdy_d;

    r_state_t    r_state_q, r_state_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [7:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [1:0]  rburst_q, rburst_d;
    logic        rerr_q, rerr_d;
    logic [7:0]  rid_q, rid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rlast_q, rlast_d;
    logic [31:0] rd_word;

    // Byte offset bits carry no information for 4-byte beats.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx, input logic [1:0] burst);
        return (burst == BURST_INCR) ? idx + 1'b1 : idx;
    endfunction

    // Ready outputs stay low until the first edge after reset release.
    assign s_axi_awready = rdy_q && (w_state_q == W_IDLE);
    assign s_axi_wready  = (w_state_q == W_DATA);
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = rdy_q && (r_state_q == R_IDLE);
    assign s_axi_rvalid  = (r_state_q == R_DATA);
    assign s_axi_rid     = rid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rlast   = rlast_q;

    // Error reads return zero; combinational read sees pre-write contents.
    assign rd_word = rerr_q ? '0 : mem[raddr_q];

    // Write FSM next-state: capture AW, stream beats, end on wlast or final count.
    always_comb begin
        rdy_d     = 1'b1;
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        wburst_d  = wburst_q;
        werr_d    = werr_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid && rdy_q) begin
                    w_state_d = W_DATA;
                    waddr_d   = s_axi_awaddr[AW+1:2];
                    wlen_d    = s_axi_awlen;
                    wcnt_d    = '0;
                    wburst_d  = s_axi_awburst;
                    werr_d    = s_axi_awburst[1] | (|s_axi_awaddr[31:AW+2]);
                    bid_d     = s_axi_awid;
                    bresp_d   = RESP_OKAY;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid) begin
                    mem_we  = !werr_q;
                    waddr_d = next_idx(waddr_q, wburst_q);
                    wcnt_d  = wcnt_q + 8'd1;
                    if (s_axi_wlast) begin
                        w_state_d = W_RESP;
                        bresp_d   = werr_q ? RESP_SLVERR : RESP_OKAY;
                    end else if (wcnt_q == wlen_q) begin
                        w_state_d = W_RESP;
                        bresp_d   = RESP_SLVERR;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read FSM next-state: one fetch cycle after AR, then one beat per rready.
    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rburst_d  = rburst_q;
        rerr_d    = rerr_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        rlast_d   = rlast_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid && rdy_q) begin
                    r_state_d = R_FETCH;
                    raddr_d   = s_axi_araddr[AW+1:2];
                    rlen_d    = s_axi_arlen;
                    rcnt_d    = '0;
                    rburst_d  = s_axi_arburst;
                    rerr_d    = s_axi_arburst[1] | (|s_axi_araddr[31:AW+2]);
                    rid_d     = s_axi_arid;
                    rresp_d   = (s_axi_arburst[1] | (|s_axi_araddr[31:AW+2])) ? RESP_SLVERR : RESP_OKAY;
                end
            end
            R_FETCH: begin
                r_state_d = R_DATA;
                rdata_d   = rd_word;
                rlast_d   = (rcnt_q == rlen_q);
                raddr_d   = next_idx(raddr_q, rburst_q);
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rlast_d   = 1'b0;
                    end else begin
                        rdata_d = rd_word;
                        raddr_d = next_idx(raddr_q, rburst_q);
                        rcnt_d  = rcnt_q + 8'd1;
                        rlast_d = ((rcnt_q + 8'd1) == rlen_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Control and output registers; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q     <= 1'b0;
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wburst_q  <= '0;
            werr_q    <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rburst_q  <= '0;
            rerr_q    <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            rdy_q     <= rdy_d;
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            wburst_q  <= wburst_d;
            werr_q    <= werr_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rburst_q  <= rburst_d;
            rerr_q    <= rerr_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            rlast_q   <= rlast_d;
        end
    end

    // Storage write with byte enables; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (s_axi_wstrb[0]) mem[waddr_q][7:0]   <= s_axi_wdata[7:0];
            if (s_axi_wstrb[1]) mem[waddr_q][15:8]  <= s_axi_wdata[15:8];
            if (s_axi_wstrb[2]) mem[waddr_q][23:16] <= s_axi_wdata[23:16];
            if (s_axi_wstrb[3]) mem[waddr_q][31:24] <= s_axi_wdata[31:24];
        end
    end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Self-checking bench for axi_mem_slave: table of write/readback vectors with a
// reference memory and a read-beat scoreboard, plus latency/backpressure/reset sequences.
module tb_axi_mem_slave;
    localparam int unsigned MEM_WORDS = 256;

    logic clk = 1'b0;
    logic rst;
    logic [7:0]  s_axi_awid;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [7:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [7:0]  s_axi_arid;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [7:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    always #5 clk = ~clk;

    axi_mem_slave #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  wburst;
        logic [3:0]  strb;
        logic [31:0] dbase;
        int          wlast_at;   // beat carrying wlast; -1 means never asserted
        logic [1:0]  exp_bresp;
        logic [1:0]  rburst;
        bit          chk0;       // compare first readback beat against exp0
        logic [31:0] exp0;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [7:0]  id;
    } rbeat_t;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] ref_mem [MEM_WORDS];
    rbeat_t exp_q[$];
    rbeat_t mon_e;
    logic [1:0] b_resp_s;
    logic [7:0] b_id_s;
    vec_t vecs[10];
    vec_t pre;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit addr_err(input logic [31:0] addr, input logic [1:0] burst);
        return burst[1] || (addr >= MEM_WORDS * 4);
    endfunction

    function automatic int unsigned beat_idx(input logic [31:0] addr, input logic [1:0] burst, input int i);
        int unsigned base;
        base = (addr >> 2) % MEM_WORDS;
        return (burst == 2'b01) ? (base + i) % MEM_WORDS : base;
    endfunction

    // Read scoreboard: every accepted R beat is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && s_axi_rvalid && s_axi_rready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rbeat: got beat data 0x%08h, expected no beat", s_axi_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("rdata", s_axi_rdata, mon_e.data);
                check("rresp", 32'(s_axi_rresp), 32'(mon_e.resp));
                check("rlast", 32'(s_axi_rlast), 32'(mon_e.last));
                check("rid",   32'(s_axi_rid),   32'(mon_e.id));
            end
        end
    end

    // ch: 0=AW, 1=W, 2=B, 3=AR. Returns just after the handshake edge.
    task automatic wait_hs(input int ch, input string name);
        int guard = 0;
        bit ok;
        forever begin
            @(negedge clk);
            case (ch)
                0: ok = s_axi_awready;
                1: ok = s_axi_wready;
                2: ok = s_axi_bvalid;
                default: ok = s_axi_arready;
            endcase
            if (ok) begin
                b_resp_s = s_axi_bresp;
                b_id_s   = s_axi_bid;
                break;
            end
            guard++;
            if (guard >= 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s_timeout: no handshake after %0d cycles, expected within 50", name, guard);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] id, input vec_t v, input string name);
        int nb;
        bit err;
        logic [31:0] d;
        int unsigned idx;
        nb  = (v.wlast_at < 0) ? int'(v.len) + 1 : v.wlast_at + 1;
        err = addr_err(v.addr, v.wburst);
        s_axi_awid = id; s_axi_awaddr = v.addr; s_axi_awlen = v.len;
        s_axi_awburst = v.wburst; s_axi_awvalid = 1'b1;
        wait_hs(0, name);
        s_axi_awvalid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            d = v.dbase + 32'(i);
            s_axi_wdata = d; s_axi_wstrb = v.strb;
            s_axi_wlast = (i == v.wlast_at); s_axi_wvalid = 1'b1;
            wait_hs(1, name);
            if (!err) begin
                idx = beat_idx(v.addr, v.wburst, i);
                for (int b = 0; b < 4; b++)
                    if (v.strb[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
        wait_hs(2, name);
        s_axi_bready = 1'b0;
        check({name, "_bresp"}, 32'(b_resp_s), 32'(v.exp_bresp));
        check({name, "_bid"},   32'(b_id_s),   32'(id));
    endtask

    task automatic push_exp(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input bit chk0, input logic [31:0] exp0);
        rbeat_t e;
        bit err;
        err = addr_err(addr, burst);
        for (int i = 0; i <= int'(len); i++) begin
            e.data = err ? 32'h0 : ref_mem[beat_idx(addr, burst, i)];
            if (i == 0 && chk0) e.data = exp0;
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (i == int'(len));
            e.id   = id;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int guard = 0;
        while (exp_q.size() != 0 && guard < budget) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_drain: %0d beats pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input bit chk0, input logic [31:0] exp0, input string name);
        push_exp(id, addr, len, burst, chk0, exp0);
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        wait_hs(3, name);
        s_axi_arvalid = 1'b0;
        drain(name, 20 + 2 * (int'(len) + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        //           addr      len  wburst strb  dbase         wlast bresp rburst chk exp0
        vecs[0] = '{32'h010, 8'd3, 2'b01, 4'hF, 32'h00000001,  3, 2'b00, 2'b01, 1'b0, 32'h0};
        vecs[1] = '{32'h040, 8'd0, 2'b01, 4'hF, 32'h11223344,  0, 2'b00, 2'b01, 1'b0, 32'h0};
        vecs[2] = '{32'h040, 8'd0, 2'b01, 4'h5, 32'hAABBCCDD,  0, 2'b00, 2'b01, 1'b1, 32'h11BB33DD};
        vecs[3] = '{32'h080, 8'd2, 2'b00, 4'hF, 32'h00000100,  2, 2'b00, 2'b00, 1'b1, 32'h00000102};
        vecs[4] = '{32'h3FC, 8'd1, 2'b01, 4'hF, 32'h00000200,  1, 2'b00, 2'b01, 1'b0, 32'h0};
        vecs[5] = '{32'h010, 8'd1, 2'b10, 4'hF, 32'hDEAD0000,  1, 2'b10, 2'b01, 1'b1, 32'h00000001};
        vecs[6] = '{32'h400, 8'd1, 2'b01, 4'hF, 32'h0000BAD0,  1, 2'b10, 2'b01, 1'b1, 32'h0};
        vecs[7] = '{32'h0A0, 8'd3, 2'b01, 4'hF, 32'h00000300,  1, 2'b00, 2'b01, 1'b0, 32'h0};
        vecs[8] = '{32'h0C0, 8'd1, 2'b01, 4'h3, 32'h00000400, -1, 2'b10, 2'b01, 1'b0, 32'h0};
        vecs[9] = '{32'h050, 8'd1, 2'b11, 4'hF, 32'h00000500,  1, 2'b10, 2'b11, 1'b1, 32'h0};

        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awburst = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arburst = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        rst = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_awready", 32'(s_axi_awready), 0);
        check("rst_arready", 32'(s_axi_arready), 0);
        check("rst_wready",  32'(s_axi_wready),  0);
        check("rst_bvalid",  32'(s_axi_bvalid),  0);
        check("rst_rvalid",  32'(s_axi_rvalid),  0);
        check("rst_rlast",   32'(s_axi_rlast),   0);
        check("rst_bresp",   32'(s_axi_bresp),   0);
        check("rst_rresp",   32'(s_axi_rresp),   0);
        check("rst_bid",     32'(s_axi_bid),     0);
        check("rst_rid",     32'(s_axi_rid),     0);
        check("rst_rdata",   s_axi_rdata,        0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_awready_pre", 32'(s_axi_awready), 0);
        @(negedge clk);
        check("rel_awready", 32'(s_axi_awready), 1);
        check("rel_arready", 32'(s_axi_arready), 1);
        @(posedge clk);
        #1;
        s_axi_rready = 1'b1;

        // Fill every word so later readbacks compare defined data.
        pre = '{32'h0, 8'd255, 2'b01, 4'hF, 32'hA5000000, 255, 2'b00, 2'b01, 1'b0, 32'h0};
        do_write(8'h01, pre, "preload");

        for (int i = 0; i < 10; i++) begin
            do_write(8'h30 + 8'(i), vecs[i], $sformatf("v%0d_wr", i));
            do_read(8'h80 + 8'(i), vecs[i].addr, vecs[i].len, vecs[i].rburst,
                    vecs[i].chk0, vecs[i].exp0, $sformatf("v%0d_rd", i));
        end

        // Read latency and backpressure on a 2-beat burst.
        push_exp(8'h90, 32'h10, 8'd1, 2'b01, 1'b0, 32'h0);
        s_axi_rready = 1'b0;
        s_axi_arid = 8'h90; s_axi_araddr = 32'h10; s_axi_arlen = 8'd1;
        s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
        wait_hs(3, "bp_ar");
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        check("bp_lat0_rvalid", 32'(s_axi_rvalid), 0);
        @(negedge clk);
        check("bp_lat1_rvalid", 32'(s_axi_rvalid), 1);
        check("bp_first_rdata", s_axi_rdata, ref_mem[4]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp_stall%0d_rvalid", k), 32'(s_axi_rvalid), 1);
            check($sformatf("bp_stall%0d_rdata", k),  s_axi_rdata, ref_mem[4]);
            check($sformatf("bp_stall%0d_rlast", k),  32'(s_axi_rlast), 0);
        end
        @(posedge clk);
        #1;
        s_axi_rready = 1'b1;
        drain("bp", 20);

        // Reset in the middle of a read burst.
        s_axi_rready = 1'b0;
        s_axi_arid = 8'hA0; s_axi_araddr = 32'h20; s_axi_arlen = 8'd3;
        s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
        wait_hs(3, "mr_ar");
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mr_pre_rvalid", 32'(s_axi_rvalid), 1);
        #2 rst = 1'b0;
        #1;
        check("mr_rvalid",  32'(s_axi_rvalid),  0);
        check("mr_arready", 32'(s_axi_arready), 0);
        check("mr_rdata",   s_axi_rdata,        0);
        check("mr_rid",     32'(s_axi_rid),     0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mr_rel_arready_pre", 32'(s_axi_arready), 0);
        @(negedge clk);
        check("mr_rel_arready", 32'(s_axi_arready), 1);
        check("mr_rel_awready", 32'(s_axi_awready), 1);
        check("mr_rel_rvalid",  32'(s_axi_rvalid),  0);
        @(posedge clk);
        #1;
        s_axi_rready = 1'b1;
        do_read(8'hB0, 32'h10, 8'd3, 2'b01, 1'b0, 32'h0, "mr_intact");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
